// File: rtl/multi_molecule_parser.sv
`default_nettype none
// ============================================================================
// Module   : multi_molecule_parser
// Purpose  : Buffers whole challenge vectors in a small FIFO and streams each
//            one out as MOLECULE_W-bit molecules, one per cycle, over a
//            valid/ready handshake. Slot 0 (LSBs) is emitted first.
// Ports    : clk, reset_n (async assert, active low)
//            global_challenges/challenge_valid/challenge_ready : input stream
//            challenge_drop   : 1-cycle pulse when a challenge is offered while full
//            current_molecule/molecule_index/molecule_valid/
//            molecule_ready/molecule_last : output stream
//            challenge_count  : challenges fully emitted, wraps silently
// Config   : PARSER_SKIP_EMPTY_EN - when defined, all-zero slots are skipped
//            (index keeps the true slot number, last marks the final non-zero
//            slot, an all-zero challenge emits nothing but is still counted).
// Revision : 1.0 - initial release
// ============================================================================
module multi_molecule_parser #(
  parameter int  CHALLENGE_W = 1024,
  parameter int  MOLECULE_W  = 256,
  parameter int  FIFO_DEPTH  = 4,
  parameter int  CNT_W       = 16,
  localparam int c_SLOTS     = CHALLENGE_W / MOLECULE_W,
  localparam int c_IDX_W     = (c_SLOTS > 1) ? $clog2(c_SLOTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CHALLENGE_W-1:0] global_challenges,
  input  logic                   challenge_valid,
  output logic                   challenge_ready,
  output logic                   challenge_drop,
  output logic [MOLECULE_W-1:0]  current_molecule,
  output logic [c_IDX_W-1:0]     molecule_index,
  output logic                   molecule_valid,
  input  logic                   molecule_ready,
  output logic                   molecule_last,
  output logic [CNT_W-1:0]       challenge_count
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  // IDLE waits for work, LOAD presents the first slot of the hold register
  // (this extra stage gives the two-edge push-to-valid latency), EMIT streams.
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_EMIT = 2'd2;

  // ---------------------------------------------------------------- FIFO
  logic [CHALLENGE_W-1:0] mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [c_PTR_W:0]       occ_q, occ_d;
  logic                   w_full, w_empty, w_push, w_pop;
  logic [CHALLENGE_W-1:0] w_head;

  assign w_full          = (occ_q == (c_PTR_W+1)'(FIFO_DEPTH));
  assign w_empty         = (occ_q == '0);
  assign w_push          = challenge_valid && !w_full;
  assign w_head          = mem_q[rd_ptr_q];
  assign challenge_ready = !w_full;

  always_comb begin
    occ_d = occ_q;
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage is not reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= global_challenges;
  end

  // ------------------------------------------------------ serializer state
  logic [1:0]             state_q, state_d;
  logic [CHALLENGE_W-1:0] hold_q, hold_d;
  logic                   valid_q, valid_d;
  logic [c_IDX_W-1:0]     idx_q, idx_d;
  logic [MOLECULE_W-1:0]  mol_q, mol_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   drop_q;

  // Per-slot "emit this slot" masks for the hold register and the FIFO head.
  logic [c_SLOTS-1:0] w_hold_mask, w_head_mask;

  for (genvar g = 0; g < c_SLOTS; g++) begin : g_mask
`ifdef PARSER_SKIP_EMPTY_EN
    assign w_hold_mask[g] = |hold_q[g*MOLECULE_W +: MOLECULE_W];
    assign w_head_mask[g] = |w_head[g*MOLECULE_W +: MOLECULE_W];
`else
    assign w_hold_mask[g] = 1'b1;
    assign w_head_mask[g] = 1'b1;
`endif
  end

  // Lowest set mask bit at or above 'from' (0 if none).
  function automatic logic [c_IDX_W-1:0] f_first_set(input logic [c_SLOTS-1:0] m,
                                                     input int from);
    f_first_set = '0;
    for (int i = c_SLOTS - 1; i >= 0; i--) begin
      if (i >= from && m[i]) f_first_set = c_IDX_W'(i);
    end
  endfunction

  // Any set mask bit strictly above 'idx' - if not, 'idx' is the last slot.
  function automatic logic f_any_after(input logic [c_SLOTS-1:0] m, input int idx);
    f_any_after = 1'b0;
    for (int i = 0; i < c_SLOTS; i++) begin
      if (i > idx && m[i]) f_any_after = 1'b1;
    end
  endfunction

  function automatic logic [MOLECULE_W-1:0] f_slot(input logic [CHALLENGE_W-1:0] v,
                                                   input logic [c_IDX_W-1:0] idx);
    f_slot = v[int'(idx)*MOLECULE_W +: MOLECULE_W];
  endfunction

  logic [c_IDX_W-1:0] w_hold_first, w_hold_next, w_head_first;
  logic               w_hold_zero, w_head_zero, w_hs;

  assign w_hold_first = f_first_set(w_hold_mask, 0);
  assign w_hold_next  = f_first_set(w_hold_mask, int'(idx_q) + 1);
  assign w_head_first = f_first_set(w_head_mask, 0);
  assign w_hold_zero  = ~|w_hold_mask;
  assign w_head_zero  = ~|w_head_mask;
  assign w_hs         = valid_q && molecule_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= c_ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (!w_empty) state_d = c_ST_LOAD;
      c_ST_LOAD: begin
        if (!w_hold_zero) state_d = c_ST_EMIT;
        else if (w_empty) state_d = c_ST_IDLE;
      end
      c_ST_EMIT: begin
        if (w_hs && last_q) begin
          if (w_empty)          state_d = c_ST_IDLE;
          else if (w_head_zero) state_d = c_ST_LOAD;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    w_pop   = 1'b0;
    hold_d  = hold_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    mol_d   = mol_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          hold_d = w_head;
        end
      end
      c_ST_LOAD: begin
        if (w_hold_zero) begin
          // Nothing to emit: count it and fetch the next one straight away.
          cnt_d = cnt_q + CNT_W'(1);
          if (!w_empty) begin
            w_pop  = 1'b1;
            hold_d = w_head;
          end
        end else begin
          valid_d = 1'b1;
          idx_d   = w_hold_first;
          mol_d   = f_slot(hold_q, w_hold_first);
          last_d  = !f_any_after(w_hold_mask, int'(w_hold_first));
        end
      end
      c_ST_EMIT: begin
        if (w_hs) begin
          if (!last_q) begin
            idx_d  = w_hold_next;
            mol_d  = f_slot(hold_q, w_hold_next);
            last_d = !f_any_after(w_hold_mask, int'(w_hold_next));
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!w_empty) begin
              w_pop  = 1'b1;
              hold_d = w_head;
              if (!w_head_zero) begin
                // Present the next challenge directly from the FIFO head so
                // there is no bubble between challenges.
                idx_d  = w_head_first;
                mol_d  = f_slot(w_head, w_head_first);
                last_d = !f_any_after(w_head_mask, int'(w_head_first));
              end else begin
                valid_d = 1'b0;
              end
            end else begin
              valid_d = 1'b0;
            end
          end
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      mol_q    <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q   <= occ_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      mol_q   <= mol_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      drop_q  <= challenge_valid && w_full;
    end
  end

  assign current_molecule = mol_q;
  assign molecule_index   = idx_q;
  assign molecule_valid   = valid_q;
  assign molecule_last    = last_q;
  assign challenge_count  = cnt_q;
  assign challenge_drop   = drop_q;

endmodule
`default_nettype wire
